// File: rtl/onehot_enc_skid_if.sv
// Handshake bundle for onehot_enc_skid; master is the environment, slave is the encoder.
`timescale 1ns/1ps
interface onehot_enc_skid_if #(
  parameter int N  = 4,
  parameter int W  = 2,
  parameter int CW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  i;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  y;
  logic          err;
  logic [CW-1:0] err_cnt;

  modport master (
    output in_valid, i, out_ready,
    input  in_ready, out_valid, y, err, err_cnt
  );

  modport slave (
    input  in_valid, i, out_ready,
    output in_ready, out_valid, y, err, err_cnt
  );
endinterface

// File: rtl/onehot_enc_skid.sv
// One-hot to binary encoder with 2-entry skid buffer; ONEHOT_ENC_PRIORITY_EN selects highest-bit encoding.
// Latency 1 cycle from input accept to out_valid; throughput 1 beat/cycle.
// Backpressure: in_ready is a register, low only when both entries are occupied.
`timescale 1ns/1ps
module onehot_enc_skid #(
  parameter int N  = 4,
  parameter int W  = 2,
  parameter int CW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  onehot_enc_skid_if.slave  bus
);

  typedef struct packed {
    logic [W-1:0] y;
    logic         err;
  } beat_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t        state_q, state_d;
  beat_t         head_q, head_d, tail_q, tail_d;
  beat_t         enc;
  logic [W-1:0]  hi;
  logic          in_ready_q, out_valid_q;
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic          in_xfer, out_xfer;

  // Ascending scan so the highest set bit wins.
  always_comb begin
    hi = '0;
    for (int k = 0; k < N; k++) begin
      if (bus.i[k]) hi = W'(k);
    end
`ifdef ONEHOT_ENC_PRIORITY_EN
    enc.y   = hi;
    enc.err = (bus.i == '0);
`else
    enc.err = (bus.i == '0) || ((bus.i & (bus.i - N'(1))) != '0);
    enc.y   = enc.err ? '0 : hi;
`endif
  end

  assign in_xfer  = bus.in_valid & in_ready_q;
  assign out_xfer = out_valid_q & bus.out_ready;

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    tail_d    = tail_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = ONE;
          head_d  = enc;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          head_d = enc;
        end else if (in_xfer) begin
          state_d = FULL;
          tail_d  = enc;
        end else if (out_xfer) begin
          state_d = EMPTY;
          head_d  = '0;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_d = ONE;
          head_d  = tail_q;
          tail_d  = '0;
        end
      end
      default: begin
        state_d = EMPTY;
        head_d  = '0;
        tail_d  = '0;
      end
    endcase
    if (in_xfer && enc.err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CW'(1);
  end

  // Handshake flags are registered from the next state, keeping out_ready off the in_ready path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      err_cnt_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      err_cnt_q   <= err_cnt_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = head_q.y;
  assign bus.err       = head_q.err;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: doc/onehot_enc_skid.md
Name: onehot_enc_skid

Overview:
- Registered one-hot-to-binary encoder: the inverse of the team's 2-to-4 / N-to-2^W decoders.
- Accepts a one-hot vector `i` under a valid/ready handshake and produces the binary index `y` plus a per-beat error flag.
- A 2-entry skid buffer keeps `in_ready` fully registered, so the block can sit between registered pipeline stages without combinational ready paths.
- Also keeps a saturating count of malformed inputs for debug.

Parameters:
- N, 4, width of one-hot input vector (N ≥ 2, power of 2).
- W, 2, output index width; must equal log2(N).
- CW, 8, width of the error counter.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  synchronous reset, active-low, sampled on rising clk.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat; registered.
- i  input  N  one-hot code; bit k set means index k.
- out_valid  output  1  `y`/`err` valid.
- out_ready  input  1  downstream accepts the beat.
- y  output  W  encoded index.
- err  output  1  beat's input was not a legal one-hot code.
- err_cnt  output  CW  saturating count of accepted beats with err=1.

Behaviour:
- Reset (rst_n=0 at posedge) sets: in_ready=1, out_valid=0, y=0, err=0, err_cnt=0, buffer EMPTY.
  - Reset takes priority over any transfer in the same cycle; a beat in flight is discarded.
- Transfers:
  - Input transfer when in_valid & in_ready at posedge.
  - Output transfer when out_valid & out_ready at posedge.
  - `i` is ignored when in_valid=0.
- Encoding, computed on the input side and stored with the beat:
  - Exactly one bit k set: y=k, err=0.
  - i==0: y=0, err=1.
  - More than one bit set: y=0, err=1 (see Optional Feature).
- Buffer states: EMPTY (0 entries), ONE (1), FULL (2). Entries are FIFO-ordered; the head drives y/err/out_valid directly from a register.
  - EMPTY + in xfer: go to ONE; out_valid=1 the next cycle. Latency is exactly 1 cycle.
  - ONE + in xfer only: go to FULL; in_ready=0 the next cycle.
  - ONE + out xfer only: go to EMPTY.
  - ONE + both: stay ONE; the new beat becomes head.
  - FULL + out xfer: go to ONE; the second entry moves to head; in_ready=1 the next cycle.
  - FULL: no input transfer is possible (in_ready=0).
- in_ready = (state != FULL), driven from a register. No combinational path from out_ready to in_ready.
- out_valid=1 in ONE/FULL. y/err stay stable while out_valid=1 and out_ready=0.
- err_cnt increments by 1 on each input transfer whose encoded err=1. It saturates at 2^CW-1 and holds; no wrap.
- Throughput is 1 beat/cycle when out_ready is held at 1.
- No X propagation: y/err are defined (0) whenever out_valid=0.

Optional Feature:
- Macro: ONEHOT_ENC_PRIORITY_EN.
- Defined: inputs with multiple bits set encode to the highest set index with err=0, matching the decoder's MSB ordering (e.g. 4'b1010 → y=3). Only i==0 flags err=1.
- Undefined: multiple set bits → y=0, err=1, counted in err_cnt.
- Handshake, latency and reset behaviour are identical in both builds.

Test Plan:
- Reset mid-stream: fill to FULL with 4'b0001, 4'b0010, then rst_n=0 for 1 cycle → next cycle out_valid=0, in_ready=1, y=0, err_cnt=0.
- Streaming, out_ready=1: send 4'b0001, 4'b0010, 4'b0100, 4'b1000 back-to-back → y=0,1,2,3 on consecutive cycles starting 1 cycle after each accept; err=0; in_ready stays 1.
- Backpressure: out_ready=0, send 4'b0100 then 4'b1000 → in_ready=0 after 2nd accept, y=2 held; raise out_ready → y=2 then 3, in_ready=1 one cycle after first drain; no beat lost or duplicated.
- Illegal codes, macro off: send 4'b0000, 4'b0110 → y=0, err=1 both beats, err_cnt=2. Macro on: 4'b0110 → y=2, err=0, and 4'b0000 → err=1, err_cnt=1.
- Saturation: CW=2, send 5 beats of 4'b0000 → err_cnt reads 1,2,3,3,3.
- Random valid/ready toggling, 1000 legal beats: output sequence equals input indices in order; y/err stable under stall.
